// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM initiator for the frame-buffer on-chip RAM: forward word-by-word block copy
// or constant fill, one RAM access per cycle, with system-wide stall (clken) support.
module onchip_mem_copy_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     fill_value,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic                  clken,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int         BE_W      = DATA_W / 8;
  localparam int         CNT_W     = ADDR_W + 1;
  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   src_ptr_r, src_ptr_s;
  logic [ADDR_W-1:0]   dst_ptr_r, dst_ptr_s;
  logic [CNT_W-1:0]    remaining_r, remaining_s;
  logic                mode_r, mode_s;
  logic [DATA_W-1:0]   fill_r, fill_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [1:0]          wait_cnt_r, wait_cnt_s;

  logic [ADDR_W-1:0]   address_r, address_s;
  logic                chipselect_r, chipselect_s;
  logic                write_r, write_s;
  logic [DATA_W-1:0]   writedata_r, writedata_s;
  logic [BE_W-1:0]     byteenable_r;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  // Next-state and datapath update; the RAM is frozen together with us, so stall just holds state.
  always_comb begin
    state_s     = state_r;
    src_ptr_s   = src_ptr_r;
    dst_ptr_s   = dst_ptr_r;
    remaining_s = remaining_r;
    mode_s      = mode_r;
    fill_s      = fill_r;
    data_s      = data_r;
    wait_cnt_s  = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count == {CNT_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            src_ptr_s   = src_addr;
            dst_ptr_s   = dst_addr;
            remaining_s = word_count;
            mode_s      = mode;
            fill_s      = fill_value;
            state_s     = mode ? ST_WR : ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        wait_cnt_s = 2'd0;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_r == LAST_WAIT) begin
          data_s  = readdata;
          state_s = ST_WR;
        end else begin
          wait_cnt_s = wait_cnt_r + 2'd1;
        end
      end
      ST_WR: begin
        src_ptr_s   = src_ptr_r + ADDR_W'(1);
        dst_ptr_s   = dst_ptr_r + ADDR_W'(1);
        remaining_s = remaining_r - CNT_W'(1);
        if (remaining_r == CNT_W'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = mode_r ? ST_WR : ST_RD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the state being entered so the registered bus lines up with it.
  always_comb begin
    chipselect_s = 1'b0;
    write_s      = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    address_s    = address_r;
    writedata_s  = writedata_r;
    case (state_s)
      ST_RD: begin
        chipselect_s = 1'b1;
        busy_s       = 1'b1;
        address_s    = src_ptr_s;
      end
      ST_WAIT: busy_s = 1'b1;
      ST_WR: begin
        chipselect_s = 1'b1;
        write_s      = 1'b1;
        busy_s       = 1'b1;
        address_s    = dst_ptr_s;
        writedata_s  = mode_s ? fill_s : data_s;
      end
      ST_DONE: done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // State, datapath and output registers; everything holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      src_ptr_r    <= {ADDR_W{1'b0}};
      dst_ptr_r    <= {ADDR_W{1'b0}};
      remaining_r  <= {CNT_W{1'b0}};
      mode_r       <= 1'b0;
      fill_r       <= {DATA_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      wait_cnt_r   <= 2'd0;
      address_r    <= {ADDR_W{1'b0}};
      chipselect_r <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= {DATA_W{1'b0}};
      byteenable_r <= {BE_W{1'b1}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (!stall) begin
      state_r      <= state_s;
      src_ptr_r    <= src_ptr_s;
      dst_ptr_r    <= dst_ptr_s;
      remaining_r  <= remaining_s;
      mode_r       <= mode_s;
      fill_r       <= fill_s;
      data_r       <= data_s;
      wait_cnt_r   <= wait_cnt_s;
      address_r    <= address_s;
      chipselect_r <= chipselect_s;
      write_r      <= write_s;
      writedata_r  <= writedata_s;
      byteenable_r <= {BE_W{1'b1}};
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign clken      = ~stall;
  assign busy       = busy_r;
  assign done       = done_r;
  assign address    = address_r;
  assign byteenable = byteenable_r;
  assign chipselect = chipselect_r;
  assign write      = write_r;
  assign writedata  = writedata_r;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master: behavioural RAM slave, array-based reference model of
// forward copy / fill, directed scenarios plus randomized operations with random stalls.
`timescale 1ns/1ps
module tb_onchip_mem_copy_master;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int RL    = 1;
  localparam int DEPTH = 1024;
  localparam int BEW   = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n, start, mode, stall;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   word_count;
  logic [DW-1:0] fill_value;
  logic          busy, done, chipselect, write, clken;
  logic [AW-1:0] address;
  logic [BEW-1:0] byteenable;
  logic [DW-1:0] writedata, readdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] ram      [DEPTH];
  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] rd_pipe  [RL];
  logic          preload;
  int            rd_log[$];
  int            wr_log[$];

  onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .fill_value(fill_value), .stall(stall), .busy(busy), .done(done),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM slave with clock enable and registered read path.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_mem[i];
    end else if (clken) begin
      for (int p = RL - 1; p > 0; p--) rd_pipe[p] <= rd_pipe[p-1];
      rd_pipe[0] <= ram[address];
      if (chipselect && write) begin
        for (int b = 0; b < BEW; b++)
          if (byteenable[b]) ram[address][8*b +: 8] <= writedata[8*b +: 8];
        wr_log.push_back(int'(address));
      end else if (chipselect) begin
        rd_log.push_back(int'(address));
      end
    end
  end
  assign readdata = rd_pipe[RL-1];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [49:0] bus_snap();
    return {address, chipselect, write, writedata, byteenable, busy, done};
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: sequential forward copy / fill of n words, addresses modulo the RAM depth.
  task automatic model_apply(input logic m, input int src, input int dst, input int n, input logic [31:0] fv);
    for (int i = 0; i < n; i++) begin
      if (m) ref_mem[(dst + i) % DEPTH] = fv;
      else   ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "/address"}, address, 0);
    check_val({tag, "/byteenable"}, byteenable, 4'hF);
    check_val({tag, "/chipselect"}, chipselect, 0);
    check_val({tag, "/write"}, write, 0);
    check_val({tag, "/writedata"}, writedata, 0);
    check_val({tag, "/busy"}, busy, 0);
    check_val({tag, "/done"}, done, 0);
  endtask

  task automatic run_op(input string name, input logic m, input int src, input int dst, input int cnt,
                        input logic [31:0] fv, input int stall_at, input int stall_len, input int abort_at);
    int k, exp_k, rd0, wr0, nw, bad;
    bit seen, busy_ok;
    logic [49:0] snap;
    rd0   = rd_log.size();
    wr0   = wr_log.size();
    exp_k = (cnt == 0) ? 0 : (m ? cnt : 3 * cnt);
    if (stall_len > 0) exp_k += stall_len;
    snap  = '0;
    @(negedge clk);
    mode = m; src_addr = AW'(src); dst_addr = AW'(dst); word_count = 11'(cnt); fill_value = fv; start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    src_addr   = AW'($urandom);
    dst_addr   = AW'($urandom);
    word_count = 11'($urandom_range(0, 1024));
    fill_value = $urandom;
    mode       = ~m;
    k = 0; seen = 0; busy_ok = 1;
    while (k < 8000) begin
      if (abort_at >= 0 && k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_idle_outputs({name, "/async_rst"});
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        nw = m ? k : k / 3;
        if (nw > cnt) nw = cnt;
        model_apply(m, src, dst, nw, fv);
        check_val({name, "/mem"}, mem_diff(), 0);
        return;
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 0;
      if (stall_len > 0 && k > stall_at && k <= stall_at + stall_len) begin
        check_val({name, "/clken_stall"}, clken, 0);
        check_val({name, "/frozen"}, bus_snap(), snap);
        if (k == stall_at + stall_len) stall = 1'b0;
      end
      if (stall_len > 0 && k == stall_at) begin
        stall = 1'b1;
        snap  = bus_snap();
      end
      start = (k == 1);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    stall = 1'b0;
    check_val({name, "/done_at"}, seen ? k : -1, exp_k);
    check_val({name, "/busy_during"}, busy_ok, 1);
    check_val({name, "/busy_at_done"}, busy, 0);
    @(negedge clk);
    check_val({name, "/done_width"}, done, 0);
    check_val({name, "/idle_busy"}, busy, 0);
    model_apply(m, src, dst, cnt, fv);
    check_val({name, "/mem"}, mem_diff(), 0);
    bad = 0;
    if (rd_log.size() - rd0 != (m ? 0 : cnt)) bad++;
    else for (int i = 0; i < rd_log.size() - rd0; i++) if (rd_log[rd0 + i] != (src + i) % DEPTH) bad++;
    check_val({name, "/rd_seq"}, bad, 0);
    bad = 0;
    if (wr_log.size() - wr0 != cnt) bad++;
    else for (int i = 0; i < cnt; i++) if (wr_log[wr0 + i] != (dst + i) % DEPTH) bad++;
    check_val({name, "/wr_seq"}, bad, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, cnt, nominal, s_at, s_len;
    logic m;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; stall = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0; fill_value = '0; preload = 1'b1;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h11; init_mem[1] = 32'h22; init_mem[2] = 32'h33; init_mem[3] = 32'h44;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_mem[i];
    @(posedge clk);
    #1 preload = 1'b0;
    check_idle_outputs("reset");
    check_val("reset/clken", clken, 1);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_op("copy4", 1'b0, 0, 100, 4, 32'h0, -1, 0, -1);
    check_val("copy4/ram100", ram[100], 32'h11);
    check_val("copy4/ram103", ram[103], 32'h44);

    r0 = rd_log.size(); w0 = wr_log.size();
    run_op("zero", 1'b0, 5, 200, 0, 32'h0, -1, 0, -1);
    check_val("zero/no_cs", (rd_log.size() - r0) + (wr_log.size() - w0), 0);

    r0 = rd_log.size();
    run_op("wrap", 1'b0, 1022, 10, 3, 32'h0, -1, 0, -1);
    if (rd_log.size() - r0 == 3) begin
      check_val("wrap/rd0", rd_log[r0], 1022);
      check_val("wrap/rd1", rd_log[r0+1], 1023);
      check_val("wrap/rd2", rd_log[r0+2], 0);
    end else begin
      check_val("wrap/rd_count", rd_log.size() - r0, 3);
    end

    run_op("fill", 1'b1, 0, 1023, 2, 32'hDEADBEEF, -1, 0, -1);
    check_val("fill/ram1023", ram[1023], 32'hDEADBEEF);
    check_val("fill/ram0", ram[0], 32'hDEADBEEF);

    run_op("stall", 1'b0, 20, 300, 4, 32'h0, 4, 5, -1);
    check_val("stall/clken_after", clken, 1);

    // Start presented while stalled in IDLE must not be taken.
    r0 = rd_log.size();
    @(negedge clk);
    stall = 1'b1; start = 1'b1; mode = 1'b0; src_addr = 10'd0; dst_addr = 10'd700; word_count = 11'd3;
    @(negedge clk);
    stall = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("idle_stall/busy", busy, 0);
    check_val("idle_stall/no_read", rd_log.size() - r0, 0);

    run_op("rst_mid", 1'b0, 40, 500, 4, 32'h0, -1, 0, 5);
    @(negedge clk);
    check_idle_outputs("rst_mid/after");
    run_op("restart", 1'b0, 500, 600, 4, 32'h0, -1, 0, -1);

    for (int it = 0; it < 30; it++) begin
      m       = 1'($urandom_range(0, 1));
      cnt     = (it == 0) ? 1024 : $urandom_range(0, 20);
      nominal = (cnt == 0) ? 0 : (m ? cnt : 3 * cnt);
      s_len   = 0;
      s_at    = -1;
      if (nominal > 0 && $urandom_range(0, 2) == 0) begin
        s_len = $urandom_range(1, 4);
        s_at  = $urandom_range(0, nominal - 1);
      end
      run_op("rand", m, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), cnt,
             $urandom, s_at, s_len, -1);
    end

    check_val("final/mem", mem_diff(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
